mc_seq_ctrl: RTL and testbench

Multi-cycle control sequencer for the 32-word unified instruction/data memory and the 12-op ALU.
- Fetches the instruction at PC and decodes it.
- Reads the operands from memory through the single shared port, drives the ALU, then writes the result back.
- All memory traffic is serialised by one FSM, so operand reads and write-back never collide.
- Sits between the top-level run control (start/stop) and the memory + ALU datapath.

---
 rtl/mc_seq_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_mc_seq_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_seq_ctrl.sv
`timescale 1ns/1ps
// Multi-cycle control sequencer: fetch, decode, operand reads, ALU execute and
// write-back, all serialised over one shared synchronous memory port.
module mc_seq_ctrl #(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned CNT_W   = 16,
    parameter logic [5:0]  HALT_OP = 6'h3F
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_y,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              error,
    output logic [CNT_W-1:0]  instr_count
);

    localparam int unsigned IMM_W   = 16;
    localparam int unsigned REG_W   = 5;
    localparam logic [5:0]  MAX_OP  = 6'd11;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_FETCH_W,
        S_DECODE,
        S_RD_A,
        S_RD_A_W,
        S_RD_B,
        S_RD_B_W,
        S_EXEC,
        S_WB,
        S_HALTED
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    // Instruction field decode from the held instruction register
    logic [5:0]       opcode;
    logic [REG_W-1:0] rd, rs, rt, shamt;
    logic [IMM_W-1:0] imm;

    assign opcode = ir_q[31:26];
    assign rd     = ir_q[25:21];
    assign rs     = ir_q[20:16];
    assign rt     = ir_q[15:11];
    assign shamt  = ir_q[10:6];
    assign imm    = ir_q[15:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state, register updates and memory strobes
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        mem_addr = pc_q;
        mem_re   = 1'b0;
        mem_we   = 1'b0;

        case (state_q)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            S_FETCH: begin
                mem_re  = 1'b1;
                state_d = S_FETCH_W;
            end
            S_FETCH_W: begin
                ir_d    = mem_rdata;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (opcode == HALT_OP) begin
                    state_d = S_HALTED;
                end else if (opcode > MAX_OP) begin
                    err_d   = 1'b1;
                    state_d = S_HALTED;
                end else begin
                    state_d = S_RD_A;
                end
            end
            S_RD_A: begin
                mem_addr = ADDR_W'(rs);
                mem_re   = 1'b1;
                state_d  = S_RD_A_W;
            end
            S_RD_A_W: begin
                a_d = mem_rdata;
                // Register ops fetch B from memory; the rest form it from the instruction
                case (opcode)
                    6'd0, 6'd1, 6'd2, 6'd3, 6'd6, 6'd7: begin
                        state_d = S_RD_B;
                    end
                    6'd5: begin
                        b_d     = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
                        state_d = S_EXEC;
                    end
                    6'd10, 6'd11: begin
                        b_d     = DATA_W'(shamt);
                        state_d = S_EXEC;
                    end
                    default: begin
                        b_d     = DATA_W'(imm);
                        state_d = S_EXEC;
                    end
                endcase
            end
            S_RD_B: begin
                mem_addr = ADDR_W'(rt);
                mem_re   = 1'b1;
                state_d  = S_RD_B_W;
            end
            S_RD_B_W: begin
                b_d     = mem_rdata;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                res_d   = alu_y;
                state_d = S_WB;
            end
            S_WB: begin
                mem_addr = ADDR_W'(rd);
                mem_we   = 1'b1;
                pc_d     = pc_q + ADDR_W'(1);
                cnt_d    = cnt_q + CNT_W'(1);
                state_d  = stop_req ? S_HALTED : S_FETCH;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem_wdata   = res_q;
    assign alu_op      = opcode[3:0];
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign pc          = pc_q;
    assign busy        = (state_q != S_IDLE) && (state_q != S_HALTED);
    assign halted      = (state_q == S_HALTED);
    assign error       = err_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_mc_seq_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for mc_seq_ctrl: a behavioural memory and ALU surround the
// sequencer; expected write-backs and status snapshots are checked by a monitor.
module tb_mc_seq_ctrl;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              stop_req = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic [3:0]        alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_y;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              halted;
    logic              error;
    logic [CNT_W-1:0]  instr_count;

    logic [DATA_W-1:0] mem [32];
    logic              ld_en = 1'b0;
    logic [4:0]        ld_addr = '0;
    logic [31:0]       ld_data = '0;

    int unsigned cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        int unsigned at;
    } wr_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    wr_t  exp_q[$];
    chk_t chk_q[$];

    always #5 clk = ~clk;

    mc_seq_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop_req   (stop_req),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_y      (alu_y),
        .pc         (pc),
        .busy       (busy),
        .halted     (halted),
        .error      (error),
        .instr_count(instr_count)
    );

    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        case (op)
            4'd0:    alu_f = a + b;
            4'd1:    alu_f = a - b;
            4'd2:    alu_f = a & b;
            4'd3:    alu_f = a | b;
            4'd4:    alu_f = a & b;
            4'd5:    alu_f = a + b;
            4'd6:    alu_f = a ^ b;
            4'd7:    alu_f = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd8:    alu_f = a | b;
            4'd9:    alu_f = a ^ b;
            4'd10:   alu_f = a << b[4:0];
            4'd11:   alu_f = a >> b[4:0];
            default: alu_f = 32'd0;
        endcase
    endfunction

    assign alu_y = alu_f(alu_op, alu_a, alu_b);

    // Self-rewriting OR-immediate at address k: word | zext(k) == word
    function automatic logic [31:0] self_word(input int k);
        self_word = {6'd8, 5'(k), 5'(k), 16'(k)};
    endfunction

    // Memory model: synchronous read, write on the rising edge, bench preload port
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    // Monitor: write-backs against the expected queue, status snapshots, invariants
    always @(negedge clk) begin
        wr_t  e;
        chk_t c;
        n_tests++;
        if (mem_re && mem_we) begin
            n_fail++;
            $display("FAIL re_we_overlap cyc=%0d re=%0b we=%0b, need not both 1", cyc, mem_re, mem_we);
        end
        if (!mem_re && !mem_we && mem_addr != pc) begin
            n_fail++;
            $display("FAIL idle_addr cyc=%0d mem_addr=%0d, need pc=%0d", cyc, mem_addr, pc);
        end
        if (mem_we) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write cyc=%0d addr=%0d data=%h", cyc, mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if (mem_addr !== e.addr || mem_wdata !== e.data || cyc != e.at) begin
                    n_fail++;
                    $display("FAIL write addr=%0d data=%h cyc=%0d, need addr=%0d data=%h cyc=%0d",
                             mem_addr, mem_wdata, cyc, e.addr, e.data, e.at);
                end
            end
        end
        while (chk_q.size() != 0) begin
            c = chk_q.pop_front();
            n_tests++;
            if (c.act !== c.exp) begin
                n_fail++;
                $display("FAIL %s got=%h need=%h", c.name, c.act, c.exp);
            end
        end
    end

    task automatic note(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.act  = act;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d, input int unsigned at);
        wr_t e;
        e.addr = a;
        e.data = d;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic poke(input logic [4:0] a, input logic [31:0] d);
        ld_addr = a;
        ld_data = d;
        ld_en   = 1'b1;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    // Returns the cycle index of the accepting edge; cycle 1 (FETCH) is c0+1
    task automatic do_start(output int unsigned c0);
        start = 1'b1;
        @(posedge clk);
        c0 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_cyc(input int unsigned t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_halted(input string name, input int budget);
        int i = 0;
        while (!halted && i < budget) begin
            @(negedge clk);
            i++;
        end
        note(name, 32'(halted), 32'd1);
    endtask

    initial begin
        int unsigned c0;

        for (int k = 0; k < 32; k++) poke(5'(k), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        note("rst_pc", 32'(pc), 32'd0);
        note("rst_busy", 32'(busy), 32'd0);
        note("rst_halted", 32'(halted), 32'd0);
        note("rst_error", 32'(error), 32'd0);
        note("rst_count", 32'(instr_count), 32'd0);
        note("rst_we_re", {30'd0, mem_we, mem_re}, 32'd0);

        // add rd1 <- m29+m30; the write lands on the next fetch address
        poke(5'd29, 32'd6);
        poke(5'd30, 32'd5);
        poke(5'd0, 32'h003D_F000);
        poke(5'd1, 32'hFC00_0000);
        poke(5'd2, 32'hFC00_0000);
        do_start(c0);
        expect_wr(5'd1, 32'd11, c0 + 9);
        expect_wr(5'd0, 32'h007B_E000, c0 + 18);
        wait_halted("t1_halt", 60);
        note("t1_halt_cyc", cyc, c0 + 22);
        note("t1_pc", 32'(pc), 32'd2);
        note("t1_count", 32'(instr_count), 32'd2);
        note("t1_error", 32'(error), 32'd0);

        // signed sub rd2 <- m30-m29
        poke(5'd0, 32'h045E_E800);
        poke(5'd1, 32'hFC00_0000);
        do_start(c0);
        expect_wr(5'd2, 32'hFFFF_FFFF, c0 + 9);
        wait_halted("t2_halt", 40);
        note("t2_halt_cyc", cyc, c0 + 13);
        note("t2_count", 32'(instr_count), 32'd1);
        note("t2_alu_a", alu_a, 32'd5);

        // addi rd3 <- m29 + (-2)
        poke(5'd0, 32'h147D_FFFE);
        do_start(c0);
        expect_wr(5'd3, 32'd4, c0 + 7);
        wait_halted("t2b_halt", 40);
        note("t2b_halt_cyc", cyc, c0 + 11);
        note("t2b_alu_b", alu_b, 32'hFFFF_FFFE);
        note("t2b_pc", 32'(pc), 32'd1);

        // shl rd4 <- m30 << 3
        poke(5'd0, 32'h289E_00C0);
        do_start(c0);
        expect_wr(5'd4, 32'd40, c0 + 7);
        wait_halted("t3_halt", 40);
        note("t3_alu_b", alu_b, 32'd3);
        note("t3_alu_a", alu_a, 32'd5);

        // illegal opcode 12: error, halt after decode, no write
        poke(5'd0, 32'h3000_0000);
        do_start(c0);
        wait_cyc(c0 + 3);
        note("t4_decode_halted", 32'(halted), 32'd0);
        note("t4_decode_busy", 32'(busy), 32'd1);
        wait_cyc(c0 + 4);
        note("t4_halted", 32'(halted), 32'd1);
        note("t4_error", 32'(error), 32'd1);
        poke(5'd0, 32'h147D_FFFE);
        do_start(c0);
        note("t4_err_clr", 32'(error), 32'd0);
        expect_wr(5'd3, 32'd4, c0 + 7);
        wait_halted("t4_rehalt", 40);
        note("t4_pc", 32'(pc), 32'd1);

        // 34 self-rewriting instructions: pc wrap, ignored start and stray stop_req
        for (int k = 0; k < 32; k++) poke(5'(k), self_word(k));
        do_start(c0);
        for (int i = 0; i < 34; i++) expect_wr(5'(i % 32), self_word(i % 32), c0 + 7 * (i + 1));
        wait_cyc(c0 + 10);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cyc(c0 + 19);
        stop_req = 1'b1;
        @(negedge clk);
        stop_req = 1'b0;
        wait_cyc(c0 + 225);
        note("t5_wrap_pc", 32'(pc), 32'd0);
        note("t5_wrap_count", 32'(instr_count), 32'd32);
        note("t5_wrap_busy", 32'(busy), 32'd1);
        wait_cyc(c0 + 238);
        stop_req = 1'b1;
        @(negedge clk);
        stop_req = 1'b0;
        note("t5_halted", 32'(halted), 32'd1);
        note("t5_pc", 32'(pc), 32'd2);
        note("t5_count", 32'(instr_count), 32'd34);

        // reset during RD_B_W of the second instruction
        poke(5'd29, 32'd6);
        poke(5'd30, 32'd5);
        poke(5'd1, 32'h003D_F000);
        do_start(c0);
        expect_wr(5'd0, 32'h2000_0000, c0 + 7);
        wait_cyc(c0 + 14);
        note("t6_pre_pc", 32'(pc), 32'd1);
        note("t6_pre_count", 32'(instr_count), 32'd1);
        #2 reset = 1'b1;
        #1;
        note("t6_rst_pc", 32'(pc), 32'd0);
        note("t6_rst_count", 32'(instr_count), 32'd0);
        note("t6_rst_busy_halt", {30'd0, busy, halted}, 32'd0);
        note("t6_rst_we_re", {30'd0, mem_we, mem_re}, 32'd0);
        note("t6_rst_alu_a", alu_a, 32'd0);
        note("t6_rst_alu_b", alu_b, 32'd0);
        note("t6_rst_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        note("t6_idle_busy", 32'(busy), 32'd0);

        // reset in the middle of a write-back drops the strobe at once
        do_start(c0);
        expect_wr(5'd0, 32'h2000_0000, c0 + 7);
        wait_cyc(c0 + 7);
        #1;
        note("t6_wb_we", 32'(mem_we), 32'd1);
        #1 reset = 1'b1;
        #1;
        note("t6_wb_rst_we", 32'(mem_we), 32'd0);
        note("t6_wb_rst_addr", 32'(mem_addr), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        repeat (3) @(negedge clk);
        note("pending_writes", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
